regfile_wb_arbiter: RTL and testbench

//  Write-side front end of the 2R1W register file. Merges two write sources onto the file's single write

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_wb_arbiter_if.sv | 34 +++
 rtl/wb_fifo.sv | 46 ++++
 rtl/regfile_wb_arbiter.sv | 99 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and the write-request record used by the register-file write front end.
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle between ID/WB/multi-cycle unit and the register-file write front end.
interface regfile_wb_arbiter_if;
    import regfile_pkg::*;

    logic                  pipe_we;
    logic [REG_ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0]     pipe_data;
    logic                  iss_valid;
    logic [REG_ADDR_W-1:0] iss_addr;
    logic                  lu_valid;
    logic [REG_ADDR_W-1:0] lu_addr;
    logic [DATA_W-1:0]     lu_data;
    logic                  lu_ready;
    logic [REG_ADDR_W-1:0] rs_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [REG_ADDR_W-1:0] dst_addr;
    logic                  stall;
    logic [NUM_REGS-1:0]   pending;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0]     rf_data;

    modport slave (
        input  pipe_we, pipe_addr, pipe_data, iss_valid, iss_addr,
        input  lu_valid, lu_addr, lu_data, rs_addr, rt_addr, dst_addr,
        output lu_ready, stall, pending, rf_we, rf_addr, rf_data
    );

    modport master (
        output pipe_we, pipe_addr, pipe_data, iss_valid, iss_addr,
        output lu_valid, lu_addr, lu_data, rs_addr, rt_addr, dst_addr,
        input  lu_ready, stall, pending, rf_we, rf_addr, rf_data
    );
endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write requests; head visible combinationally.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: full/empty flags; push while full is ignored unless a pop happens the same cycle.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  wb_req_t push_dat,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0] r_wr_ptr;
    logic [PW:0] r_rd_ptr;
    wb_req_t     r_mem [DEPTH];
    logic        w_push_ok;
    logic        w_pop_ok;

    // Pointers carry a wrap bit so equal indices distinguish full from empty.
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);
    assign head      = r_mem[r_rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[PW-1:0]] <= push_dat;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges WB-stage writes and buffered mul/div results onto the single RF write port; keeps the pending scoreboard.
// Latency: pipe writes 0 cycles, results >=1 cycle via FIFO (0 when WB_LU_BYPASS_EN and path idle).
// Backpressure: pipe never stalled; lu_ready drops while the FIFO is full; stall from the scoreboard.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);
    logic                  w_pipe_act;
    logic                  w_lu_acc;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    wb_req_t               w_head;
    wb_req_t               w_lu_req;
    logic                  w_retire;
    logic [REG_ADDR_W-1:0] w_retire_addr;
    logic [NUM_REGS-1:0]   w_set;
    logic [NUM_REGS-1:0]   w_clr;
    logic                  w_rf_we;
    logic [REG_ADDR_W-1:0] w_rf_addr;
    logic [DATA_W-1:0]     w_rf_data;
    logic [NUM_REGS-1:0]   r_pending;

    assign w_lu_req = '{addr: bus.lu_addr, data: bus.lu_data};

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push),
        .push_dat (w_lu_req),
        .pop      (w_pop),
        .head     (w_head),
        .full     (w_full),
        .empty    (w_empty)
    );

    always_comb begin
        w_pipe_act    = bus.pipe_we && (bus.pipe_addr != '0);
        w_lu_acc      = bus.lu_valid && !reset && !w_full;
`ifdef WB_LU_BYPASS_EN
        w_bypass      = w_lu_acc && !w_pipe_act && w_empty && (bus.lu_addr != '0);
`else
        w_bypass      = 1'b0;
`endif
        // r0 results are acknowledged but never buffered.
        w_push        = w_lu_acc && (bus.lu_addr != '0) && !w_bypass;
        w_pop         = !reset && !w_pipe_act && !w_empty;
        w_rf_we       = 1'b0;
        w_rf_addr     = '0;
        w_rf_data     = '0;
        w_retire      = 1'b0;
        w_retire_addr = '0;
        if (!reset && w_pipe_act) begin
            w_rf_we   = 1'b1;
            w_rf_addr = bus.pipe_addr;
            w_rf_data = bus.pipe_data;
        end else if (w_pop) begin
            w_rf_we       = 1'b1;
            w_rf_addr     = w_head.addr;
            w_rf_data     = w_head.data;
            w_retire      = 1'b1;
            w_retire_addr = w_head.addr;
        end else if (w_bypass) begin
            w_rf_we       = 1'b1;
            w_rf_addr     = bus.lu_addr;
            w_rf_data     = bus.lu_data;
            w_retire      = 1'b1;
            w_retire_addr = bus.lu_addr;
        end
        w_set = '0;
        w_clr = '0;
        if (bus.iss_valid && (bus.iss_addr != '0)) w_set[bus.iss_addr] = 1'b1;
        if (w_retire) w_clr[w_retire_addr] = 1'b1;
    end

    // Set is OR-ed after the clear so a same-cycle issue survives the retire.
    always_ff @(posedge clk) begin
        if (reset) r_pending <= '0;
        else       r_pending <= (r_pending & ~w_clr) | w_set;
    end

    assign bus.lu_ready = !reset && !w_full;
    assign bus.pending  = reset ? '0 : r_pending;
    assign bus.stall    = !reset && (r_pending[bus.rs_addr] | r_pending[bus.rt_addr] | r_pending[bus.dst_addr]);
    assign bus.rf_we    = w_rf_we;
    assign bus.rf_addr  = w_rf_addr;
    assign bus.rf_data  = w_rf_data;

    a_no_waw_issue: assert property (@(posedge clk) disable iff (reset)
        !(bus.iss_valid && (bus.iss_addr != '0) && r_pending[bus.iss_addr]
          && !(w_retire && (w_retire_addr == bus.iss_addr))));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, issue/retire, collision, full FIFO, r0, set/clear race.
module tb_regfile_wb_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        bus.pipe_we   = 1'b0; bus.pipe_addr = '0; bus.pipe_data = '0;
        bus.iss_valid = 1'b0; bus.iss_addr  = '0;
        bus.lu_valid  = 1'b0; bus.lu_addr   = '0; bus.lu_data   = '0;
        bus.rs_addr   = '0;   bus.rt_addr   = '0; bus.dst_addr  = '0;
    endtask

    // Inputs change on the falling edge; outputs are checked 1ns later.
    task automatic step();
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); #1;
        checks++; if (bus.rf_we !== 1'b0)    begin failures++; $display("FAIL rst_rf_we got=%b exp=0", bus.rf_we); end
        checks++; if (bus.lu_ready !== 1'b0) begin failures++; $display("FAIL rst_lu_ready got=%b exp=0", bus.lu_ready); end
        checks++; if (bus.stall !== 1'b0)    begin failures++; $display("FAIL rst_stall got=%b exp=0", bus.stall); end
        step(); reset = 1'b0; #1;
        checks++; if (bus.pending !== 32'h0) begin failures++; $display("FAIL rst_pending got=%h exp=0", bus.pending); end
        checks++; if (bus.lu_ready !== 1'b1) begin failures++; $display("FAIL rst_lu_ready_after got=%b exp=1", bus.lu_ready); end
    endtask

    task automatic test_reset_mid();
        step(); bus.iss_valid = 1'b1; bus.iss_addr = 5'd2;
        step(); bus.iss_valid = 1'b1; bus.iss_addr = 5'd8;
        step(); bus.pipe_we = 1'b1; bus.pipe_addr = 5'd4; bus.lu_valid = 1'b1; bus.lu_addr = 5'd2; bus.lu_data = 32'h11;
        step(); bus.pipe_we = 1'b1; bus.pipe_addr = 5'd4; bus.lu_valid = 1'b1; bus.lu_addr = 5'd8; bus.lu_data = 32'h22;
        step(); bus.pipe_we = 1'b1; bus.pipe_addr = 5'd4; #1;
        checks++; if (bus.pending !== 32'h0000_0104) begin failures++; $display("FAIL mid_setup_pending got=%h exp=00000104", bus.pending); end
        checks++; if (bus.rf_addr !== 5'd4)          begin failures++; $display("FAIL mid_setup_rf_addr got=%0d exp=4", bus.rf_addr); end
        step(); reset = 1'b1; bus.rs_addr = 5'd8; #1;
        checks++; if (bus.rf_we !== 1'b0)    begin failures++; $display("FAIL mid_in_rst_rf_we got=%b exp=0", bus.rf_we); end
        checks++; if (bus.pending !== 32'h0) begin failures++; $display("FAIL mid_in_rst_pending got=%h exp=0", bus.pending); end
        checks++; if (bus.stall !== 1'b0)    begin failures++; $display("FAIL mid_in_rst_stall got=%b exp=0", bus.stall); end
        step(); reset = 1'b0; #1;
        checks++; if (bus.pending !== 32'h0) begin failures++; $display("FAIL mid_after_pending got=%h exp=0", bus.pending); end
        checks++; if (bus.rf_we !== 1'b0)    begin failures++; $display("FAIL mid_after_rf_we got=%b exp=0", bus.rf_we); end
        checks++; if (bus.lu_ready !== 1'b1) begin failures++; $display("FAIL mid_after_lu_ready got=%b exp=1", bus.lu_ready); end
        step(); #1;
        checks++; if (bus.rf_we !== 1'b0)    begin failures++; $display("FAIL mid_stale_rf_we got=%b exp=0", bus.rf_we); end
    endtask

    task automatic test_issue_retire();
        step(); bus.iss_valid = 1'b1; bus.iss_addr = 5'd8;
        step(); bus.rs_addr = 5'd8; #1;
        checks++; if (bus.stall !== 1'b1)             begin failures++; $display("FAIL ir_stall got=%b exp=1", bus.stall); end
        checks++; if (bus.pending !== 32'h0000_0100)  begin failures++; $display("FAIL ir_pending got=%h exp=00000100", bus.pending); end
        step(); bus.rs_addr = 5'd8;
        step(); bus.rs_addr = 5'd8; bus.lu_valid = 1'b1; bus.lu_addr = 5'd8; bus.lu_data = 32'hDEAD_BEEF; #1;
        checks++; if (bus.lu_ready !== 1'b1) begin failures++; $display("FAIL ir_lu_ready got=%b exp=1", bus.lu_ready); end
        checks++; if (bus.stall !== 1'b1)    begin failures++; $display("FAIL ir_stall_accept got=%b exp=1", bus.stall); end
`ifdef WB_LU_BYPASS_EN
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_addr !== 5'd8 || bus.rf_data !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL ir_write got=%b/%0d/%h exp=1/8/deadbeef", bus.rf_we, bus.rf_addr, bus.rf_data); end
        step(); bus.rs_addr = 5'd8; #1;
`else
        checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL ir_early_rf_we got=%b exp=0", bus.rf_we); end
        step(); bus.rs_addr = 5'd8; #1;
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_addr !== 5'd8 || bus.rf_data !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL ir_write got=%b/%0d/%h exp=1/8/deadbeef", bus.rf_we, bus.rf_addr, bus.rf_data); end
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL ir_stall_retire got=%b exp=1", bus.stall); end
        step(); bus.rs_addr = 5'd8; #1;
`endif
        checks++; if (bus.pending[8] !== 1'b0) begin failures++; $display("FAIL ir_pending_clr got=%b exp=0", bus.pending[8]); end
        checks++; if (bus.stall !== 1'b0)      begin failures++; $display("FAIL ir_stall_clr got=%b exp=0", bus.stall); end
    endtask

    task automatic test_collision();
        step(); bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
        step(); bus.pipe_we = 1'b1; bus.pipe_addr = 5'd3; bus.pipe_data = 32'd5;
        bus.lu_valid = 1'b1; bus.lu_addr = 5'd9; bus.lu_data = 32'h99; #1;
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_addr !== 5'd3 || bus.rf_data !== 32'd5) begin
            failures++; $display("FAIL col_pipe got=%b/%0d/%h exp=1/3/5", bus.rf_we, bus.rf_addr, bus.rf_data); end
        step(); #1;
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_addr !== 5'd9 || bus.rf_data !== 32'h99) begin
            failures++; $display("FAIL col_lu got=%b/%0d/%h exp=1/9/99", bus.rf_we, bus.rf_addr, bus.rf_data); end
        checks++; if (bus.pending[9] !== 1'b1) begin failures++; $display("FAIL col_pending_hold got=%b exp=1", bus.pending[9]); end
        step(); #1;
        checks++; if (bus.pending[9] !== 1'b0) begin failures++; $display("FAIL col_pending_clr got=%b exp=0", bus.pending[9]); end
        checks++; if (bus.rf_we !== 1'b0)      begin failures++; $display("FAIL col_idle_rf_we got=%b exp=0", bus.rf_we); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            step(); bus.pipe_we = 1'b1; bus.pipe_addr = 5'd4; bus.pipe_data = 32'h44;
            bus.lu_valid = 1'b1; bus.lu_addr = 5'(10 + i); bus.lu_data = 32'hA0 + 32'(i); #1;
            checks++; if (bus.lu_ready !== 1'b1) begin failures++; $display("FAIL full_fill%0d_ready got=%b exp=1", i, bus.lu_ready); end
        end
        step(); bus.pipe_we = 1'b1; bus.pipe_addr = 5'd4; bus.lu_valid = 1'b1; bus.lu_addr = 5'd14; #1;
        checks++; if (bus.lu_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", bus.lu_ready); end
        checks++; if (bus.rf_addr !== 5'd4)  begin failures++; $display("FAIL full_pipe_addr got=%0d exp=4", bus.rf_addr); end
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            checks++; if (bus.rf_we !== 1'b1 || bus.rf_addr !== 5'(10 + i) || bus.rf_data !== 32'hA0 + 32'(i)) begin
                failures++; $display("FAIL full_drain%0d got=%b/%0d/%h exp=1/%0d/%h", i, bus.rf_we, bus.rf_addr, bus.rf_data, 10 + i, 32'hA0 + 32'(i)); end
            checks++; if (bus.lu_ready !== (i != 0)) begin failures++; $display("FAIL full_drain%0d_ready got=%b exp=%b", i, bus.lu_ready, (i != 0)); end
        end
        step(); #1;
        checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL full_empty_rf_we got=%b exp=0", bus.rf_we); end
    endtask

    task automatic test_zero_reg();
        step(); bus.pipe_we = 1'b1; bus.pipe_addr = 5'd5; bus.pipe_data = 32'h55;
        bus.lu_valid = 1'b1; bus.lu_addr = 5'd20; bus.lu_data = 32'h20; bus.iss_valid = 1'b1; bus.iss_addr = 5'd0;
        step(); bus.pipe_we = 1'b1; bus.pipe_addr = 5'd0; bus.pipe_data = 32'h77;
        bus.lu_valid = 1'b1; bus.lu_addr = 5'd0; bus.lu_data = 32'h66; bus.iss_valid = 1'b1; bus.iss_addr = 5'd0; #1;
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_addr !== 5'd20 || bus.rf_data !== 32'h20) begin
            failures++; $display("FAIL zero_drain got=%b/%0d/%h exp=1/20/20", bus.rf_we, bus.rf_addr, bus.rf_data); end
        checks++; if (bus.lu_ready !== 1'b1) begin failures++; $display("FAIL zero_lu_ready got=%b exp=1", bus.lu_ready); end
        checks++; if (bus.pending !== 32'h0) begin failures++; $display("FAIL zero_pending got=%h exp=0", bus.pending); end
        step(); #1;
        checks++; if (bus.rf_we !== 1'b0)    begin failures++; $display("FAIL zero_no_r0 got=%b exp=0", bus.rf_we); end
        checks++; if (bus.pending !== 32'h0) begin failures++; $display("FAIL zero_pending_after got=%h exp=0", bus.pending); end
    endtask

    task automatic test_same_cycle();
        step(); bus.iss_valid = 1'b1; bus.iss_addr = 5'd7;
        step(); bus.pipe_we = 1'b1; bus.pipe_addr = 5'd4; bus.lu_valid = 1'b1; bus.lu_addr = 5'd7; bus.lu_data = 32'h77;
        step(); bus.iss_valid = 1'b1; bus.iss_addr = 5'd7; #1;
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_addr !== 5'd7) begin
            failures++; $display("FAIL sc_retire got=%b/%0d exp=1/7", bus.rf_we, bus.rf_addr); end
        step(); bus.rs_addr = 5'd7; #1;
        checks++; if (bus.pending !== 32'h0000_0080) begin failures++; $display("FAIL sc_pending got=%h exp=00000080", bus.pending); end
        checks++; if (bus.stall !== 1'b1)            begin failures++; $display("FAIL sc_stall got=%b exp=1", bus.stall); end
        step(); bus.lu_valid = 1'b1; bus.lu_addr = 5'd7; bus.lu_data = 32'h78;
        step();
        step(); #1;
        checks++; if (bus.pending !== 32'h0) begin failures++; $display("FAIL sc_cleanup got=%h exp=0", bus.pending); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle();
        test_reset();
        test_reset_mid();
        test_issue_retire();
        test_collision();
        test_full();
        test_zero_reg();
        test_same_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
